// File: rtl/frame_arb_pkg.sv
// frame_arb_pkg: shared state encoding, grant encoding and sizing constants for the SDRAM frame arbiter
package frame_arb_pkg;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY} state_t;
  localparam int BANK_W = 2;
  localparam logic GR_WR = 1'b0;
  localparam logic GR_RD = 1'b1;
  localparam int BURST_SHIFT = 8;
endpackage

// File: rtl/frame_burst_ptr.sv
// frame_burst_ptr: per-side burst pointer, frame-active flag, deferred restart and end-of-frame pulse
module frame_burst_ptr #(
  parameter int FRAME_BURSTS = 1200,
  parameter int PTR_W = $clog2(FRAME_BURSTS)
) (
  input  logic             clk,
  input  logic             rst_133,
  input  logic             start,
  input  logic             sel,
  input  logic             done,
  output logic [PTR_W-1:0] ptr,
  output logic             act,
  output logic             rise
);
  logic pend;
  logic last;
  logic restart;
  assign last = ptr == PTR_W'(FRAME_BURSTS - 1);
  // a start arriving with the completing burst (or latched earlier) overrides end-of-frame
  assign restart = start || pend;
  always_ff @(posedge clk or negedge rst_133)
    if (!rst_133) begin
      ptr  <= '0;
      act  <= 1'b0;
      pend <= 1'b0;
      rise <= 1'b0;
    end else begin
      rise <= done && last && !restart;
      if (done) begin
        ptr  <= (last || restart) ? '0 : ptr + 1'b1;
        act  <= restart || (act && !last);
        pend <= 1'b0;
      end else if (start && sel)
        pend <= 1'b1;
      else if (start) begin
        ptr <= '0;
        act <= 1'b1;
      end
    end
endmodule

// File: rtl/sdram_frame_arbiter.sv
// sdram_frame_arbiter: shares the SDRAM command port between camera write and VGA read bursts
module sdram_frame_arbiter
  import frame_arb_pkg::*;
#(
  parameter int BURST_LEN    = 1 << BURST_SHIFT,
  parameter int FRAME_BURSTS = 1200,
  parameter int LVL_W        = 10,
  parameter int OFS_W        = 20,
  parameter int URGENT_SPACE = 768
) (
  input  logic              clk,
  input  logic              rst_133,
  input  logic              cam_frame_start,
  input  logic              vga_frame_start,
  input  logic [LVL_W-1:0]  cam_fifo_level,
  input  logic [LVL_W-1:0]  vga_fifo_space,
  input  logic [BANK_W-1:0] cam_bank,
  input  logic [BANK_W-1:0] vga_bank,
  output logic              cmd_valid,
  output logic              cmd_wr,
  output logic [BANK_W-1:0] cmd_bank,
  output logic [OFS_W-1:0]  cmd_addr,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic              cam_rise,
  output logic              vga_rise
);
  localparam int PTR_W = $clog2(FRAME_BURSTS);
  localparam int SH    = $clog2(BURST_LEN);
  state_t state, nxt;
  logic last_grant;
  logic [PTR_W-1:0] cam_ptr, vga_ptr;
  logic cam_act, vga_act, wr_el, rd_el, gnt_wr, gnt_rd, in_wr, in_rd;
  always_comb begin
    in_wr  = state == WR_REQ || state == WR_BUSY;
    in_rd  = state == RD_REQ || state == RD_BUSY;
    wr_el  = cam_act && cam_fifo_level >= LVL_W'(BURST_LEN);
    rd_el  = vga_act && vga_fifo_space >= LVL_W'(BURST_LEN);
    gnt_rd = state == IDLE && rd_el &&
             (!wr_el || vga_fifo_space >= LVL_W'(URGENT_SPACE) || last_grant == GR_WR);
    gnt_wr = state == IDLE && wr_el && !gnt_rd;
    nxt    = state;
    case (state)
      IDLE:    nxt = gnt_wr ? WR_REQ : gnt_rd ? RD_REQ : IDLE;
      WR_REQ:  nxt = cmd_ack ? WR_BUSY : WR_REQ;
      WR_BUSY: nxt = cmd_done ? IDLE : WR_BUSY;
      RD_REQ:  nxt = cmd_ack ? RD_BUSY : RD_REQ;
      RD_BUSY: nxt = cmd_done ? IDLE : RD_BUSY;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_133)
    if (!rst_133) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_133)
    if (!rst_133) begin
      cmd_valid  <= 1'b0;
      cmd_wr     <= 1'b0;
      cmd_bank   <= '0;
      cmd_addr   <= '0;
      last_grant <= GR_RD;
    end else begin
      cmd_valid <= nxt == WR_REQ || nxt == RD_REQ;
      if (gnt_wr || gnt_rd) begin
        cmd_wr     <= gnt_wr;
        cmd_bank   <= gnt_wr ? cam_bank : vga_bank;
        cmd_addr   <= OFS_W'({gnt_wr ? cam_ptr : vga_ptr, SH'(0)});
        last_grant <= gnt_wr ? GR_WR : GR_RD;
      end
    end
  frame_burst_ptr #(.FRAME_BURSTS(FRAME_BURSTS), .PTR_W(PTR_W)) u_cam (
    .clk(clk), .rst_133(rst_133), .start(cam_frame_start), .sel(in_wr || gnt_wr),
    .done(cmd_done && state == WR_BUSY), .ptr(cam_ptr), .act(cam_act), .rise(cam_rise)
  );
  frame_burst_ptr #(.FRAME_BURSTS(FRAME_BURSTS), .PTR_W(PTR_W)) u_vga (
    .clk(clk), .rst_133(rst_133), .start(vga_frame_start), .sel(in_rd || gnt_rd),
    .done(cmd_done && state == RD_BUSY), .ptr(vga_ptr), .act(vga_act), .rise(vga_rise)
  );
endmodule
